// File: rtl/dram_frame_reader.sv
// dram_frame_reader: reads one frame back from DRAM in single 512-bit beats,
// gathers three beats per 64-pixel group and streams 24-bit pixels.
// Ports: m_axi_aclk, reset (sync, active-high); start/busy/done control;
// dram_read_en/addr/busy/valid/data single-outstanding read port;
// pix_d0/d1/d2, pix_valid/pix_ready, pix_sof/pix_eof pixel stream.
module dram_frame_reader #(
    parameter int                         DRAM_ADDR_WIDTH  = 32,
    parameter logic [DRAM_ADDR_WIDTH-1:0] DRAM_ADDR_BASE   = 32'h80000000,
    parameter int                         DRAM_DATA_WIDTH  = 512,
    parameter int                         PIXELS_PER_FRAME = 4096
) (
    input  logic                       m_axi_aclk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       dram_read_en,
    output logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
    input  logic                       dram_read_busy,
    input  logic                       dram_read_valid,
    input  logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
    output logic [7:0]                 pix_d0,
    output logic [7:0]                 pix_d1,
    output logic [7:0]                 pix_d2,
    output logic                       pix_valid,
    input  logic                       pix_ready,
    output logic                       pix_sof,
    output logic                       pix_eof
);

    localparam int NGROUPS = PIXELS_PER_FRAME / 64;
    localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam int BW      = $clog2(3 * DRAM_DATA_WIDTH);
    localparam int DW      = DRAM_DATA_WIDTH;
    localparam logic [GW-1:0] LAST_GRP = GW'(NGROUPS - 1);
    localparam logic [DRAM_ADDR_WIDTH-1:0] STRIDE =
        DRAM_ADDR_WIDTH'(DRAM_DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE
    } state_t;

    state_t                     state, state_n;
    logic [1:0]                 beat_idx, beat_n;
    logic [GW-1:0]              group_cnt, group_n;
    logic [5:0]                 pix_idx, pidx_n;
    logic [DRAM_ADDR_WIDTH-1:0] addr_n;
    logic [DW-1:0]              chunk0, chunk1, chunk2;
    logic [DW-1:0]              c0_n, c1_n, c2_n;
    logic [3*DW-1:0]            buf_n;
    logic [BW-1:0]              bit_base;
    logic [23:0]                pix_n;
    logic                       busy_n, done_n, en_n;
    logic                       valid_n, sof_n, eof_n, load;

    always_comb begin
        state_n = state;
        beat_n  = beat_idx;
        group_n = group_cnt;
        pidx_n  = pix_idx;
        addr_n  = dram_read_addr;
        c0_n    = chunk0;
        c1_n    = chunk1;
        c2_n    = chunk2;
        busy_n  = busy;
        done_n  = 1'b0;
        en_n    = 1'b0;
        valid_n = pix_valid;
        load    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    beat_n  = '0;
                    group_n = '0;
                    pidx_n  = '0;
                    addr_n  = DRAM_ADDR_BASE;
                    busy_n  = 1'b1;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (!dram_read_busy) begin
                    en_n    = 1'b1;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dram_read_valid) begin
                    if (beat_idx == 2'd0)
                        c0_n = dram_read_data;
                    else if (beat_idx == 2'd1)
                        c1_n = dram_read_data;
                    else
                        c2_n = dram_read_data;
                    addr_n = dram_read_addr + STRIDE;
                    if (beat_idx == 2'd2) begin
                        // pixel 0 is loaded straight from the incoming beat
                        beat_n  = '0;
                        pidx_n  = '0;
                        valid_n = 1'b1;
                        load    = 1'b1;
                        state_n = S_DRAIN;
                    end else begin
                        beat_n  = beat_idx + 2'd1;
                        state_n = S_REQ;
                    end
                end
            end
            S_DRAIN: begin
                if (pix_ready) begin
                    if (pix_idx == 6'd63) begin
                        valid_n = 1'b0;
                        pidx_n  = '0;
                        if (group_cnt == LAST_GRP) begin
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                            state_n = S_DONE;
                        end else begin
                            group_n = group_cnt + GW'(1);
                            state_n = S_REQ;
                        end
                    end else begin
                        pidx_n = pix_idx + 6'd1;
                        load   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        buf_n    = {c2_n, c1_n, c0_n};
        bit_base = BW'(pidx_n) * BW'(24);
        pix_n    = {pix_d2, pix_d1, pix_d0};
        sof_n    = pix_sof;
        eof_n    = pix_eof;
        if (load) begin
            pix_n = buf_n[bit_base +: 24];
            sof_n = (group_n == '0) && (pidx_n == '0);
            eof_n = (group_n == LAST_GRP) && (pidx_n == 6'd63);
        end else if (!valid_n) begin
            sof_n = 1'b0;
            eof_n = 1'b0;
        end
    end

    always_ff @(posedge m_axi_aclk) begin
        if (reset) begin
            state          <= S_IDLE;
            beat_idx       <= '0;
            group_cnt      <= '0;
            pix_idx        <= '0;
            chunk0         <= '0;
            chunk1         <= '0;
            chunk2         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            dram_read_en   <= 1'b0;
            dram_read_addr <= DRAM_ADDR_BASE;
            pix_valid      <= 1'b0;
            pix_sof        <= 1'b0;
            pix_eof        <= 1'b0;
            pix_d0         <= '0;
            pix_d1         <= '0;
            pix_d2         <= '0;
        end else begin
            state          <= state_n;
            beat_idx       <= beat_n;
            group_cnt      <= group_n;
            pix_idx        <= pidx_n;
            chunk0         <= c0_n;
            chunk1         <= c1_n;
            chunk2         <= c2_n;
            busy           <= busy_n;
            done           <= done_n;
            dram_read_en   <= en_n;
            dram_read_addr <= addr_n;
            pix_valid      <= valid_n;
            pix_sof        <= sof_n;
            pix_eof        <= eof_n;
            pix_d0         <= pix_n[7:0];
            pix_d1         <= pix_n[15:8];
            pix_d2         <= pix_n[23:16];
        end
    end

endmodule

// File: tb/tb_dram_frame_reader.sv
// tb_dram_frame_reader: directed bench for dram_frame_reader with a
// byte-level DRAM model and a pixel monitor (128-pixel frames).
module tb_dram_frame_reader;

    localparam int          AW   = 32;
    localparam int          DW   = 512;
    localparam int          PPF  = 128;
    localparam int          NREQ = 6;
    localparam logic [31:0] BASE = 32'h80000000;

    logic          m_axi_aclk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          dram_read_en;
    logic [AW-1:0] dram_read_addr;
    logic          dram_read_busy;
    logic          dram_read_valid;
    logic [DW-1:0] dram_read_data;
    logic [7:0]    pix_d0, pix_d1, pix_d2;
    logic          pix_valid, pix_ready, pix_sof, pix_eof;

    logic          mdl_valid, spur_valid;
    logic [DW-1:0] mdl_data, spur_data;

    assign dram_read_valid = mdl_valid | spur_valid;
    assign dram_read_data  = spur_valid ? spur_data : mdl_data;

    int checks     = 0;
    int failures   = 0;
    int ready_mode = 0;
    int done_cnt   = 0;
    int pend       = 0;
    int n;
    logic          saw_en;
    logic [AW-1:0] pend_addr;
    time           beat_time = 0;
    logic [AW-1:0] req_q[$];
    logic [25:0]   pix_q[$];

    logic [26:0] cur, prev_out;
    logic prev_pv = 1'b0, prev_pr = 1'b0;
    logic prev_rst = 1'b1, prev_eof_hs = 1'b0;

    dram_frame_reader #(
        .DRAM_ADDR_WIDTH (AW),
        .DRAM_ADDR_BASE  (BASE),
        .DRAM_DATA_WIDTH (DW),
        .PIXELS_PER_FRAME(PPF)
    ) dut (
        .m_axi_aclk     (m_axi_aclk),
        .reset          (reset),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .dram_read_en   (dram_read_en),
        .dram_read_addr (dram_read_addr),
        .dram_read_busy (dram_read_busy),
        .dram_read_valid(dram_read_valid),
        .dram_read_data (dram_read_data),
        .pix_d0         (pix_d0),
        .pix_d1         (pix_d1),
        .pix_d2         (pix_d2),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_sof        (pix_sof),
        .pix_eof        (pix_eof)
    );

    always #5 m_axi_aclk = ~m_axi_aclk;

    function automatic logic [7:0] beat_byte(input logic [31:0] a,
                                             input int i);
        logic [31:0] v;
        v = ((a - BASE) >> 6) * 32'd37 + 32'(i) * 32'd11 + 32'd5;
        return v[7:0];
    endfunction

    function automatic logic [DW-1:0] beat_data(input logic [31:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < 64; i++) d[8*i +: 8] = beat_byte(a, i);
        return d;
    endfunction

    // {sof, eof, d2, d1, d0}: byte j of pixel p is byte 3p+j of its group
    function automatic logic [25:0] exp_pix(input int k);
        int g, p, b;
        logic [31:0] a;
        logic [23:0] v;
        g = k / 64;
        p = k % 64;
        for (int j = 0; j < 3; j++) begin
            b = 3 * p + j;
            a = BASE + 32'((3 * g + b / 64) * 64);
            v[8*j +: 8] = beat_byte(a, b % 64);
        end
        return {k == 0, k == PPF - 1, v};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge m_axi_aclk);
        #1;
    endtask

    task automatic clear();
        pix_q.delete();
        req_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_en"}, dram_read_en, 0);
        check({tag, "_addr"}, dram_read_addr, BASE);
        check({tag, "_valid"}, pix_valid, 0);
        check({tag, "_marks"}, {pix_sof, pix_eof}, 0);
        check({tag, "_pix"}, {pix_d2, pix_d1, pix_d0}, 0);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_cnt < 1 && k < 3000) begin
            tick();
            k++;
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        repeat (2) tick();
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_npix"}, pix_q.size(), PPF);
        for (int k = 0; k < PPF; k++)
            if (k < pix_q.size())
                check($sformatf("%s_pix%0d", tag, k), pix_q[k], exp_pix(k));
        check({tag, "_nreq"}, req_q.size(), NREQ);
        for (int b = 0; b < NREQ; b++)
            if (b < req_q.size())
                check($sformatf("%s_addr%0d", tag, b), req_q[b],
                      BASE + 32'(b * 64));
        clear();
    endtask

    // DRAM: answers each request 3 cycles later
    initial begin
        mdl_valid = 1'b0;
        mdl_data  = '0;
        pend_addr = '0;
        forever begin
            @(negedge m_axi_aclk);
            mdl_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mdl_valid = 1'b1;
                    mdl_data  = beat_data(pend_addr);
                    beat_time = $time;
                end
            end
            if (dram_read_en) begin
                req_q.push_back(dram_read_addr);
                pend_addr = dram_read_addr;
                pend      = 3;
            end
        end
    end

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge m_axi_aclk);
            #1;
            if (ready_mode == 1)
                pix_ready = ($urandom_range(0, 2) != 0);
            else
                pix_ready = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge m_axi_aclk);
            cur = {pix_valid, pix_sof, pix_eof, pix_d2, pix_d1, pix_d0};
            if (prev_pv && !prev_pr && !prev_rst)
                check("hold_stable", cur, prev_out);
            if (!pix_valid)
                check("mark_gated", {pix_sof, pix_eof}, 0);
            if (pix_valid && !prev_pv && !prev_rst)
                check("beat_to_pix", $time - beat_time, 10);
            if (pix_valid && pix_ready)
                pix_q.push_back({pix_sof, pix_eof, pix_d2, pix_d1, pix_d0});
            if (done) begin
                done_cnt++;
                check("done_after_eof", prev_eof_hs, 1);
            end
            prev_eof_hs = pix_valid && pix_ready && pix_eof;
            prev_out    = cur;
            prev_pv     = pix_valid;
            prev_pr     = pix_ready;
            prev_rst    = reset;
        end
    end

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        dram_read_busy = 1'b0;
        spur_valid     = 1'b0;
        spur_data      = {16{32'hDEADBEEF}};
        repeat (3) tick();
        check_reset_outs("rst");
        reset = 1'b0;
        tick();

        // basic frame
        clear();
        pulse_start();
        check("start_busy", busy, 1);
        check("start_no_en", dram_read_en, 0);
        tick();
        check("first_req", {dram_read_en, dram_read_addr}, {1'b1, BASE});
        wait_done("basic");
        check_frame("basic");

        // DRAM busy, then start colliding with done
        dram_read_busy = 1'b1;
        pulse_start();
        saw_en = 1'b0;
        repeat (10) begin
            tick();
            if (dram_read_en) saw_en = 1'b1;
        end
        check("busy_no_en", saw_en, 0);
        dram_read_busy = 1'b0;
        tick();
        check("busy_req", {dram_read_en, dram_read_addr}, {1'b1, BASE});
        n = 0;
        while (!(pix_valid && pix_ready && pix_eof) && n < 3000) begin
            tick();
            n++;
        end
        check("eof_seen", pix_eof, 1);
        tick();
        check("done_pulse", done, 1);
        pulse_start();
        check("collide_idle", busy, 0);
        repeat (5) tick();
        check("collide_no_req", req_q.size(), NREQ);
        check("collide_done_cnt", done_cnt, 1);
        check_frame("busy");

        // back-pressure with a mid-frame start
        ready_mode = 1;
        pulse_start();
        repeat (40) tick();
        pulse_start();
        check("mid_busy", busy, 1);
        wait_done("bp");
        ready_mode = 0;
        check_frame("bp");

        // reset while presenting pixel 30
        pulse_start();
        n = 0;
        while (pix_q.size() < 30 && n < 500) begin
            tick();
            n++;
        end
        check("at30_cnt", pix_q.size(), 30);
        check("at30_pix", {pix_sof, pix_eof, pix_d2, pix_d1, pix_d0},
              exp_pix(30));
        reset = 1'b1;
        tick();
        check_reset_outs("mid_rst");
        reset      = 1'b0;
        spur_valid = 1'b1;
        tick();
        spur_valid = 1'b0;
        repeat (3) tick();
        check("late_beat_idle", busy, 0);
        clear();
        pulse_start();
        wait_done("after_rst");
        check_frame("after_rst");

        // spurious beats in IDLE and in DRAIN
        ready_mode = 1;
        spur_valid = 1'b1;
        tick();
        spur_valid = 1'b0;
        pulse_start();
        n = 0;
        while (!pix_valid && n < 200) begin
            tick();
            n++;
        end
        check("spur_drain", pix_valid, 1);
        repeat (5) tick();
        spur_valid = 1'b1;
        tick();
        spur_valid = 1'b0;
        wait_done("spur");
        ready_mode = 0;
        check_frame("spur");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
